elevador_n_andares: RTL and testbench
=====================================

// Module: elevador_n_andares
// PURPOSE
//  Parametrised elevator controller for N_FLOORS floors, successor of the 3-floor controller.
//  Latches cabin (bd_n) and hall (bf_n) calls into a pending-request register.
//  Serves calls in sweep order: keeps direction while calls remain ahead.
//  Models floor-to-floor travel time and door dwell with one shared counter.
//  Drives motor (sobe/desce) and door; sits between button decode and the motor/door drivers.
// PARAMETERS
//  N_FLOORS      4   number of floors, >=2; floors numbered 0..N_FLOORS-1
//  TRAVEL_CYCLES 8   clock cycles to travel one floor, >=1
//  DOOR_CYCLES   6   clock cycles door stays open, >=1
//  (localparam FW = $clog2(N_FLOORS); counter wide enough for max(TRAVEL,DOOR)_CYCLES)
// PORTS
//  clock         in   1         system clock; all state changes on rising edge
//  reset         in   1         synchronous, active-high
//  bd_n          in   N_FLOORS  cabin buttons, active-low, bit i = floor i
//  bf_n          in   N_FLOORS  hall buttons, active-low, bit i = floor i
//  sobe          out  1         motor up, registered
//  desce         out  1         motor down, registered
//  porta_aberta  out  1         door open, registered
//  andar         out  FW        current floor, registered
//  pedidos       out  N_FLOORS  pending-request register
// BEHAVIOUR
//  Reset (edge with reset=1): state=IDLE, andar=0, pedidos=0, sobe=desce=porta_aberta=0,
//   dir=UP, counter=0; all pending calls dropped; reset mid-travel or mid-door likewise.
//  Request latch: on each edge, pedidos[i] <= 1 if bd_n[i]==0 or bf_n[i]==0.
//   Held buttons are level-treated (re-set each cycle). Exception: i==andar while in DOOR
//   -> not latched; instead restarts the door counter (door stays open DOOR_CYCLES more).
//  ahead_up = |pedidos above andar; ahead_dn = |pedidos below andar.
//  FSM states: IDLE, MOVE_UP, MOVE_DN, DOOR.
//   IDLE:  pedidos[andar] -> DOOR; else ahead_up&&(dir==UP||!ahead_dn) -> MOVE_UP, dir=UP;
//          else ahead_dn -> MOVE_DN, dir=DN; else stay. Decision takes 1 edge after latch.
//   MOVE_UP: sobe=1. Counter counts TRAVEL_CYCLES cycles; on terminal edge andar<=andar+1,
//          counter=0; if pedidos[andar+1] -> DOOR, else stay MOVE_UP (a call ahead must exist).
//   MOVE_DN: mirror of MOVE_UP with desce=1, andar-1.
//   DOOR:  porta_aberta=1, sobe=desce=0; pedidos[andar] cleared on entry edge;
//          after DOOR_CYCLES cycles: calls in dir -> MOVE in dir; else calls opposite ->
//          MOVE opposite, dir flipped; else IDLE.
//  Invariants: sobe&desce never 1; porta_aberta never with sobe|desce;
//   andar never exceeds N_FLOORS-1 or goes below 0 (no MOVE_UP at top / MOVE_DN at 0).
//  Calls latched mid-travel for the floor being approached are served on arrival;
//   calls for a floor just passed wait for the reverse sweep.
//  Simultaneous set of pedidos[j] and clear of pedidos[andar] (j!=andar): both take effect.
// TESTING (N_FLOORS=4, TRAVEL_CYCLES=8, DOOR_CYCLES=6)
//  1 Reset held 2 cycles, buttons all 1 -> andar=0, pedidos=0, all outputs 0, stays IDLE.
//  2 bf_n[2]=0 one cycle at edge k -> pedidos=4'b0100 after k; sobe=1 from k+1 for 16
//    cycles; andar=1 at k+9, 2 at k+17; porta_aberta 6 cycles, pedidos=0; then IDLE.
//  3 At andar=0 idle, pulse bd_n[0]=0 -> porta_aberta=1 one edge later, no sobe/desce, IDLE after 6.
//  4 From 1 moving up toward 3, pulse floors 0 and 2 -> stops at 2, then 3, then desce to 0;
//    andar sequence 2,3,2,1,0; pedidos=0 at end.
//  5 Door open at floor 2, hold bf_n[2]=0 for 10 cycles -> door open until 6 cycles after release.
//  6 Reset asserted mid-travel (sobe=1, andar=1) -> next edge sobe=0, andar=0, pedidos=0, IDLE.

Source files
------------

// File: rtl/elevador_n_andares.sv
// Elevator controller for N_FLOORS floors.
// Latches cabin and hall calls into a pending-request register. Calls are served in
// sweep order, so the cabin keeps its direction while calls remain ahead of it.
// One shared counter times both the floor-to-floor travel and the door dwell.
// The motor and door outputs are registered, so they change only at clock edges.
module elevador_n_andares #(
  parameter int N_FLOORS      = 4,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 6,
  localparam int FW           = $clog2(N_FLOORS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] bd_n,
  input  logic [N_FLOORS-1:0] bf_n,
  output logic                sobe,
  output logic                desce,
  output logic                porta_aberta,
  output logic [FW-1:0]       andar,
  output logic [N_FLOORS-1:0] pedidos
);

  localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [FW-1:0] TOP_FLOOR = FW'(N_FLOORS - 1);
  localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] DOOR_LAST   = CW'(DOOR_CYCLES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MOVE_UP = 2'd1;
  localparam logic [1:0] S_MOVE_DN = 2'd2;
  localparam logic [1:0] S_DOOR    = 2'd3;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  logic [1:0]          state, state_next;
  logic                dir, dir_next;
  logic [CW-1:0]       cnt, cnt_next;
  logic [FW-1:0]       andar_next;
  logic [FW-1:0]       andar_up, andar_dn;
  logic [N_FLOORS-1:0] calls, latch_mask, clear_mask, pending_now;
  logic                ahead_up, ahead_dn;

  assign calls       = ~bd_n | ~bf_n;
  assign pending_now = pedidos | calls;
  assign andar_up    = andar + FW'(1);
  assign andar_dn    = andar - FW'(1);

  // Any registered call strictly above / strictly below the current floor.
  always_comb begin
    ahead_up = 1'b0;
    ahead_dn = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (FW'(i) > andar) ahead_up = ahead_up | pedidos[i];
      if (FW'(i) < andar) ahead_dn = ahead_dn | pedidos[i];
    end
  end

  // Next-state, counter, floor and request-mask decisions.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latch).
    state_next = state;
    dir_next   = dir;
    andar_next = andar;
    cnt_next   = '0;
    clear_mask = '0;
    latch_mask = calls;

    case (state)
      S_IDLE: begin
        if (pedidos[andar]) begin
          state_next        = S_DOOR;
          clear_mask[andar] = 1'b1;
        end else if (ahead_up && (dir == DIR_UP || !ahead_dn)) begin
          state_next = S_MOVE_UP;
          dir_next   = DIR_UP;
        end else if (ahead_dn) begin
          state_next = S_MOVE_DN;
          dir_next   = DIR_DN;
        end
      end

      S_MOVE_UP: begin
        if (cnt == TRAVEL_LAST) begin
          andar_next = andar_up;
          if (pending_now[andar_up]) begin
            state_next           = S_DOOR;
            clear_mask[andar_up] = 1'b1;
          end else if (andar_up == TOP_FLOOR) begin
            // Cannot happen while a call ahead exists; keeps the cabin off the roof anyway.
            state_next = S_IDLE;
          end
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end

      S_MOVE_DN: begin
        if (cnt == TRAVEL_LAST) begin
          andar_next = andar_dn;
          if (pending_now[andar_dn]) begin
            state_next           = S_DOOR;
            clear_mask[andar_dn] = 1'b1;
          end else if (andar_dn == '0) begin
            state_next = S_IDLE;
          end
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end

      default: begin // S_DOOR
        // A call for the floor the door is open at keeps the door open instead of latching.
        latch_mask[andar] = 1'b0;
        if (calls[andar]) begin
          cnt_next = '0;
        end else if (cnt == DOOR_LAST) begin
          if (dir == DIR_UP && ahead_up) begin
            state_next = S_MOVE_UP;
          end else if (dir == DIR_DN && ahead_dn) begin
            state_next = S_MOVE_DN;
          end else if (dir == DIR_UP && ahead_dn) begin
            state_next = S_MOVE_DN;
            dir_next   = DIR_DN;
          end else if (dir == DIR_DN && ahead_up) begin
            state_next = S_MOVE_UP;
            dir_next   = DIR_UP;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
    endcase
  end

  // State registers and registered outputs; synchronous reset drops every pending call.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state        <= S_IDLE;
      dir          <= DIR_UP;
      cnt          <= '0;
      andar        <= '0;
      pedidos      <= '0;
      sobe         <= 1'b0;
      desce        <= 1'b0;
      porta_aberta <= 1'b0;
    end else begin
      state        <= state_next;
      dir          <= dir_next;
      cnt          <= cnt_next;
      andar        <= andar_next;
      pedidos      <= (pedidos | latch_mask) & ~clear_mask;
      sobe         <= (state_next == S_MOVE_UP);
      desce        <= (state_next == S_MOVE_DN);
      porta_aberta <= (state_next == S_DOOR);
    end
  end

endmodule

// File: tb/tb_elevador_n_andares.sv
// Self-checking bench for elevador_n_andares with N_FLOORS=4, TRAVEL_CYCLES=8, DOOR_CYCLES=6.
// Directed vector table for the single-sweep cases, hand-written sequences for the
// multi-stop sweep and for reset during travel.
module tb_elevador_n_andares;

  logic       clock;
  logic       reset;
  logic [3:0] bd_n;
  logic [3:0] bf_n;
  logic       sobe;
  logic       desce;
  logic       porta_aberta;
  logic [1:0] andar;
  logic [3:0] pedidos;

  int tests_run = 0;
  int tests_failed = 0;
  int violations = 0;

  elevador_n_andares #(
    .N_FLOORS     (4),
    .TRAVEL_CYCLES(8),
    .DOOR_CYCLES  (6)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bd_n        (bd_n),
    .bf_n        (bf_n),
    .sobe        (sobe),
    .desce       (desce),
    .porta_aberta(porta_aberta),
    .andar       (andar),
    .pedidos     (pedidos)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Safety invariants sampled every cycle away from the active edge.
  always @(negedge clock) begin
    if ((sobe && desce) || (porta_aberta && (sobe || desce)) || (andar > 2'd3))
      violations++;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       rst;
    logic [3:0] bd_n;
    logic [3:0] bf_n;
    int         hold;
    logic [8:0] exp; // {sobe, desce, porta_aberta, andar[1:0], pedidos[3:0]}
  } vec_t;

  function automatic vec_t v(input logic r, input logic [3:0] bd, input logic [3:0] bf,
                             input int h, input logic s, input logic d, input logic p,
                             input logic [1:0] a, input logic [3:0] ped);
    vec_t t;
    t.rst  = r;
    t.bd_n = bd;
    t.bf_n = bf;
    t.hold = h;
    t.exp  = {s, d, p, a, ped};
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {sobe, desce, porta_aberta, andar, pedidos};
  endfunction

  vec_t vecs[28];
  int   andar_seq[$];
  int   stop_seq[$];

  initial begin
    int         exp_andar[5];
    int         exp_stop[3];
    logic [1:0] last_andar;
    logic       last_porta;
    logic       found;

    exp_andar = '{2, 3, 2, 1, 0};
    exp_stop  = '{2, 3, 0};

    // rst, bd_n, bf_n, hold edges, then expected sobe, desce, porta, andar, pedidos
    // Reset held two edges, then idle with no calls.
    vecs[0]  = v(1, 4'hF, 4'hF,  2, 0, 0, 0, 2'd0, 4'h0);
    vecs[1]  = v(0, 4'hF, 4'hF,  3, 0, 0, 0, 2'd0, 4'h0);
    // Cabin call at the current floor: door opens one edge after latch, closes after 6.
    vecs[2]  = v(0, 4'hE, 4'hF,  1, 0, 0, 0, 2'd0, 4'h1);
    vecs[3]  = v(0, 4'hF, 4'hF,  1, 0, 0, 1, 2'd0, 4'h0);
    vecs[4]  = v(0, 4'hF, 4'hF,  5, 0, 0, 1, 2'd0, 4'h0);
    vecs[5]  = v(0, 4'hF, 4'hF,  1, 0, 0, 0, 2'd0, 4'h0);
    // Floor-1 call latched on the same edge floor 0 is cleared: both take effect.
    vecs[6]  = v(0, 4'hE, 4'hF,  1, 0, 0, 0, 2'd0, 4'h1);
    vecs[7]  = v(0, 4'hD, 4'hF,  1, 0, 0, 1, 2'd0, 4'h2);
    vecs[8]  = v(0, 4'hF, 4'hF,  5, 0, 0, 1, 2'd0, 4'h2);
    vecs[9]  = v(0, 4'hF, 4'hF,  1, 1, 0, 0, 2'd0, 4'h2);
    vecs[10] = v(0, 4'hF, 4'hF,  8, 0, 0, 1, 2'd1, 4'h0);
    vecs[11] = v(0, 4'hF, 4'hF,  6, 0, 0, 0, 2'd1, 4'h0);
    // Reset from floor 1 returns to floor 0.
    vecs[12] = v(1, 4'hF, 4'hF,  1, 0, 0, 0, 2'd0, 4'h0);
    // Hall call at floor 2: 16 cycles of sobe, floor 1 at k+9, floor 2 at k+17, 6 cycles of door.
    vecs[13] = v(0, 4'hF, 4'hB,  1, 0, 0, 0, 2'd0, 4'h4);
    vecs[14] = v(0, 4'hF, 4'hF,  1, 1, 0, 0, 2'd0, 4'h4);
    vecs[15] = v(0, 4'hF, 4'hF,  7, 1, 0, 0, 2'd0, 4'h4);
    vecs[16] = v(0, 4'hF, 4'hF,  1, 1, 0, 0, 2'd1, 4'h4);
    vecs[17] = v(0, 4'hF, 4'hF,  7, 1, 0, 0, 2'd1, 4'h4);
    vecs[18] = v(0, 4'hF, 4'hF,  1, 0, 0, 1, 2'd2, 4'h0);
    vecs[19] = v(0, 4'hF, 4'hF,  5, 0, 0, 1, 2'd2, 4'h0);
    vecs[20] = v(0, 4'hF, 4'hF,  1, 0, 0, 0, 2'd2, 4'h0);
    vecs[21] = v(0, 4'hF, 4'hF,  2, 0, 0, 0, 2'd2, 4'h0);
    // Door at floor 2 with its hall button held 10 cycles: open until 6 cycles after release.
    vecs[22] = v(0, 4'hB, 4'hF,  1, 0, 0, 0, 2'd2, 4'h4);
    vecs[23] = v(0, 4'hF, 4'hF,  1, 0, 0, 1, 2'd2, 4'h0);
    vecs[24] = v(0, 4'hF, 4'hB, 10, 0, 0, 1, 2'd2, 4'h0);
    vecs[25] = v(0, 4'hF, 4'hF,  5, 0, 0, 1, 2'd2, 4'h0);
    vecs[26] = v(0, 4'hF, 4'hF,  1, 0, 0, 0, 2'd2, 4'h0);
    // Reset from floor 2.
    vecs[27] = v(1, 4'hF, 4'hF,  1, 0, 0, 0, 2'd0, 4'h0);

    reset = 1'b1;
    bd_n  = 4'hF;
    bf_n  = 4'hF;
    @(negedge clock);

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      bd_n  = vecs[i].bd_n;
      bf_n  = vecs[i].bf_n;
      repeat (vecs[i].hold) @(posedge clock);
      @(negedge clock);
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end
    reset = 1'b0;
    bd_n  = 4'hF;
    bf_n  = 4'hF;

    // Sweep: call floor 3 from floor 0; once at floor 1, call floors 0 and 2.
    bd_n = 4'b0111;
    @(posedge clock);
    @(negedge clock);
    bd_n = 4'hF;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (andar == 2'd1) found = 1'b1;
      else @(negedge clock);
    end
    check("sweep_reach_floor1", 32'(found), 32'd1);
    bd_n = 4'b1010;
    @(posedge clock);
    @(negedge clock);
    bd_n = 4'hF;
    check("sweep_calls_latched", 32'(pedidos), 32'hD);
    check("sweep_still_up", 32'(sobe), 32'd1);

    last_andar = andar;
    last_porta = porta_aberta;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (andar != last_andar) andar_seq.push_back(int'(andar));
      if (porta_aberta && !last_porta) stop_seq.push_back(int'(andar));
      last_andar = andar;
      last_porta = porta_aberta;
    end
    check("sweep_floor_count", 32'(andar_seq.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < andar_seq.size())
        check($sformatf("sweep_floor%0d", i), 32'(andar_seq[i]), 32'(exp_andar[i]));
    check("sweep_stop_count", 32'(stop_seq.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < stop_seq.size())
        check($sformatf("sweep_stop%0d", i), 32'(stop_seq[i]), 32'(exp_stop[i]));
    check("sweep_end_idle", 32'(outs()), 32'h0);

    // Reset during upward travel at floor 1.
    bf_n = 4'b0111;
    @(posedge clock);
    @(negedge clock);
    bf_n = 4'hF;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (andar == 2'd1 && sobe) found = 1'b1;
      else @(negedge clock);
    end
    check("midtravel_reach_floor1", 32'(found), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("midtravel_reset", 32'(outs()), 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("midtravel_idle_after", 32'(outs()), 32'h0);

    check("invariants", 32'(violations), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
